mcb_port_arbiter: RTL and testbench

Shares one memory-controller write port (command FIFO plus write-data FIFO) between two requesters: requester 0 is the UART loader, requester 1 is the CPU/bus write path. The block grants the port to one requester at a time, waits for memory calibration, and drains the controller's FIFOs before handing the port over. This keeps bursts from different owners from interleaving. It sits between the requesters and the memory controller port pins.

---
 rtl/mcb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mcb_port_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mcb_port_arbiter.sv
// mcb_port_arbiter: grants one MCB write port (command + write-data FIFOs)
// to one of two requesters at a time. It waits for calibration and drains
// the controller FIFOs between owners so bursts never interleave.
module mcb_port_arbiter #(
  parameter bit PRIORITY0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        cmd_en0,
  input  logic [2:0]  cmd_instr0,
  input  logic [5:0]  cmd_bl0,
  input  logic [29:0] cmd_addr0,
  input  logic        wr_en0,
  input  logic [31:0] wr_data0,
  input  logic [3:0]  wr_mask0,
  input  logic        cmd_en1,
  input  logic [2:0]  cmd_instr1,
  input  logic [5:0]  cmd_bl1,
  input  logic [29:0] cmd_addr1,
  input  logic        wr_en1,
  input  logic [31:0] wr_data1,
  input  logic [3:0]  wr_mask1,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  input  logic        mem_cmd_empty,
  input  logic        mem_wr_empty,
  output logic        violation,
  output logic        owner
);

  typedef enum logic [2:0] {WAIT_CAL, IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t state, state_nxt;
  logic   owner_nxt;
  logic   bad_strobe;

  // Grants decode straight from the state register, so they are
  // registered and drop the instant reset hits.
  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  // Any strobe from a requester not holding the grant is illegal.
  assign bad_strobe = ((cmd_en0 | wr_en0) & ~gnt0) |
                      ((cmd_en1 | wr_en1) & ~gnt1);

  // State, owner and sticky violation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_CAL;
      owner     <= 1'b1;
      violation <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      violation <= violation | bad_strobe;
    end
  end

  // Next-state logic; owner is updated on entry to an OWN state.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      WAIT_CAL: if (calib_done) state_nxt = IDLE;
      IDLE: begin
        if (req0 && req1) begin
          // Round-robin hands the port to whoever did not own it last.
          if (PRIORITY0 || owner) begin
            state_nxt = OWN0;
            owner_nxt = 1'b0;
          end else begin
            state_nxt = OWN1;
            owner_nxt = 1'b1;
          end
        end else if (req0) begin
          state_nxt = OWN0;
          owner_nxt = 1'b0;
        end else if (req1) begin
          state_nxt = OWN1;
          owner_nxt = 1'b1;
        end
      end
      OWN0:  if (!req0) state_nxt = DRAIN;
      OWN1:  if (!req1) state_nxt = DRAIN;
      DRAIN: if (mem_cmd_empty && mem_wr_empty) state_nxt = IDLE;
      default: state_nxt = WAIT_CAL;
    endcase
  end

  // Port mux: the owner's signals pass through, everything is 0 otherwise.
  always_comb begin
    mem_cmd_en        = 1'b0;
    mem_cmd_instr     = '0;
    mem_cmd_bl        = '0;
    mem_cmd_byte_addr = '0;
    mem_wr_en         = 1'b0;
    mem_wr_data       = '0;
    mem_wr_mask       = '0;
    if (gnt0) begin
      mem_cmd_en        = cmd_en0;
      mem_cmd_instr     = cmd_instr0;
      mem_cmd_bl        = cmd_bl0;
      mem_cmd_byte_addr = cmd_addr0;
      mem_wr_en         = wr_en0;
      mem_wr_data       = wr_data0;
      mem_wr_mask       = wr_mask0;
    end else if (gnt1) begin
      mem_cmd_en        = cmd_en1;
      mem_cmd_instr     = cmd_instr1;
      mem_cmd_bl        = cmd_bl1;
      mem_cmd_byte_addr = cmd_addr1;
      mem_wr_en         = wr_en1;
      mem_wr_data       = wr_data1;
      mem_wr_mask       = wr_mask1;
    end
  end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Randomized bench for mcb_port_arbiter. Two instances (fixed priority and
// round-robin) share one stimulus stream; each is compared every cycle to a
// transaction-level model of who holds the port.
module tb_mcb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib_done = 1'b0;
  logic [1:0] req = '0, cmd_en = '0, wr_en = '0;
  logic [1:0][2:0]  cmd_instr = '0;
  logic [1:0][5:0]  cmd_bl = '0;
  logic [1:0][29:0] cmd_addr = '0;
  logic [1:0][31:0] wr_data = '0;
  logic [1:0][3:0]  wr_mask = '0;
  logic mem_cmd_empty = 1'b1, mem_wr_empty = 1'b1;

  logic [1:0] g0, g1, mce, mwe, viol, own;
  logic [1:0][2:0]  mci;
  logic [1:0][5:0]  mcb;
  logic [1:0][29:0] mca;
  logic [1:0][31:0] mwd;
  logic [1:0][3:0]  mwm;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 2; p++) begin : g_dut
    mcb_port_arbiter #(.PRIORITY0(p == 0)) u_dut (
      .clk(clk), .rst(rst), .calib_done(calib_done),
      .req0(req[0]), .req1(req[1]), .gnt0(g0[p]), .gnt1(g1[p]),
      .cmd_en0(cmd_en[0]), .cmd_instr0(cmd_instr[0]), .cmd_bl0(cmd_bl[0]),
      .cmd_addr0(cmd_addr[0]), .wr_en0(wr_en[0]), .wr_data0(wr_data[0]),
      .wr_mask0(wr_mask[0]),
      .cmd_en1(cmd_en[1]), .cmd_instr1(cmd_instr[1]), .cmd_bl1(cmd_bl[1]),
      .cmd_addr1(cmd_addr[1]), .wr_en1(wr_en[1]), .wr_data1(wr_data[1]),
      .wr_mask1(wr_mask[1]),
      .mem_cmd_en(mce[p]), .mem_cmd_instr(mci[p]), .mem_cmd_bl(mcb[p]),
      .mem_cmd_byte_addr(mca[p]), .mem_wr_en(mwe[p]), .mem_wr_data(mwd[p]),
      .mem_wr_mask(mwm[p]), .mem_cmd_empty(mem_cmd_empty),
      .mem_wr_empty(mem_wr_empty), .violation(viol[p]), .owner(own[p])
    );
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: per instance, whether calibrated, who holds the port (-1 none),
  // whether a handover drain is pending, last owner, sticky violation.
  bit cal[2], drn[2], mviol[2];
  int hold[2], mown[2];

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      cal[p] = 0; drn[p] = 0; mviol[p] = 0; hold[p] = -1; mown[p] = 1;
    end
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void model_step();
    for (int p = 0; p < 2; p++) begin
      int pick;
      for (int r = 0; r < 2; r++)
        if ((cmd_en[r] || wr_en[r]) && hold[p] != r) mviol[p] = 1;
      if (!cal[p]) cal[p] = calib_done;
      else if (hold[p] >= 0) begin
        if (!req[hold[p]]) begin hold[p] = -1; drn[p] = 1; end
      end else if (drn[p]) begin
        if (mem_cmd_empty && mem_wr_empty) drn[p] = 0;
      end else if (req != 2'b00) begin
        if (req == 2'b11) pick = (p == 0) ? 0 : (mown[p] == 0 ? 1 : 0);
        else pick = req[1] ? 1 : 0;
        hold[p] = pick; mown[p] = pick;
      end
    end
  endfunction

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      int h;
      h = hold[p];
      chk($sformatf("gnt0[%0d]", p), 64'(g0[p]), 64'(h == 0));
      chk($sformatf("gnt1[%0d]", p), 64'(g1[p]), 64'(h == 1));
      chk($sformatf("owner[%0d]", p), 64'(own[p]), 64'(mown[p]));
      chk($sformatf("violation[%0d]", p), 64'(viol[p]), 64'(mviol[p]));
      chk($sformatf("mem_cmd_en[%0d]", p), 64'(mce[p]), h >= 0 ? 64'(cmd_en[h]) : 64'd0);
      chk($sformatf("mem_wr_en[%0d]", p), 64'(mwe[p]), h >= 0 ? 64'(wr_en[h]) : 64'd0);
      chk($sformatf("mem_cmd[%0d]", p), {25'd0, mci[p], mcb[p], mca[p]},
          h >= 0 ? {25'd0, cmd_instr[h], cmd_bl[h], cmd_addr[h]} : 64'd0);
      chk($sformatf("mem_wr[%0d]", p), {28'd0, mwm[p], mwd[p]},
          h >= 0 ? {28'd0, wr_mask[h], wr_data[h]} : 64'd0);
    end
  endtask

  initial begin
    model_reset();
    for (int seg = 0; seg < 12; seg++) begin
      int cal_delay, ref_inst, empty_pct;
      bit dirty;
      cal_delay = (seg == 0) ? 50 : int'($urandom_range(0, 8));
      ref_inst  = seg % 2;
      dirty     = (seg % 3 == 2);
      empty_pct = (seg % 4 == 1) ? 25 : 70;
      // Asynchronous reset mid-cycle with both write strobes forced high:
      // grants and mem enables must collapse before any clock edge.
      @(negedge clk);
      wr_en = 2'b11; cmd_en = 2'b11;
      #2 rst = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rst_gnt[%0d]", p), {g1[p], g0[p]}, 2'b00);
        chk($sformatf("rst_wr_en[%0d]", p), {mce[p], mwe[p]}, 2'b00);
        chk($sformatf("rst_owner[%0d]", p), 64'(own[p]), 64'd1);
        chk($sformatf("rst_viol[%0d]", p), 64'(viol[p]), 64'd0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0; calib_done = 1'b0;
      for (int cyc = 0; cyc < 250; cyc++) begin
        // Requests: held for many cycles, occasionally toggling.
        for (int r = 0; r < 2; r++) begin
          if (seg == 0 && cyc < 60) req[r] = (r == 0);
          else if (req[r]) req[r] = ($urandom_range(0, 11) != 0);
          else req[r] = ($urandom_range(0, 5) == 0);
          cmd_en[r] = (dirty || hold[ref_inst] == r) && ($urandom_range(0, 2) == 0);
          wr_en[r]  = (dirty || hold[ref_inst] == r) && ($urandom_range(0, 1) == 0);
          if (dirty && hold[ref_inst] != r && $urandom_range(0, 19) != 0) begin
            cmd_en[r] = 1'b0; wr_en[r] = 1'b0;
          end
          cmd_instr[r] = 3'($urandom);
          cmd_bl[r]    = 6'($urandom);
          cmd_addr[r]  = 30'($urandom);
          wr_data[r]   = $urandom;
          wr_mask[r]   = 4'($urandom);
        end
        calib_done    = (cyc >= cal_delay);
        mem_cmd_empty = ($urandom_range(0, 99) < empty_pct);
        mem_wr_empty  = ($urandom_range(0, 99) < empty_pct);
        #1 check_all();
        model_step();
        @(negedge clk);
      end
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
